// File: rtl/slice_seq_pkg.sv
// Shared definitions for the slice stage sequencer.
//   state_t          : sequencer FSM states (IDLE, RUN)
//   FIELD_W          : width of each per-stage field in STAGE_DELAY / STAGE_CPB
//   DEF_STAGE_DELAY  : default start offsets (stage0 = DC VLC, stage1 = AC VLC)
//   DEF_STAGE_CPB    : default window cycles per block
package slice_seq_pkg;

    localparam int FIELD_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2*FIELD_W-1:0] DEF_STAGE_DELAY = {16'd54, 16'd10};
    localparam logic [2*FIELD_W-1:0] DEF_STAGE_CPB   = {16'd63, 16'd1};

endpackage

// File: rtl/slice_stage_window.sv
// Per-stage window decoder. Purely combinational on registered inputs so the
// outputs are glitch-free relative to the clock.
// Ports:
//   run       in   sequencer is in RUN
//   beg       in   registered window start B_s
//   fin       in   registered window end E_s (exclusive)
//   count     in   global sequence counter
//   active    out  B_s <= count < E_s while running
//   flush     out  count == E_s while running (cycle after the window)
//   local_cnt out  count - B_s inside the window, else 0
module slice_stage_window #(
    parameter int CNT_W = 32
) (
    input  logic             run,
    input  logic [CNT_W-1:0] beg,
    input  logic [CNT_W-1:0] fin,
    input  logic [CNT_W-1:0] count,
    output logic             active,
    output logic             flush,
    output logic [CNT_W-1:0] local_cnt
);

    assign active    = run && (count >= beg) && (count < fin);
    assign flush     = run && (count == fin);
    assign local_cnt = active ? (count - beg) : '0;

endmodule

// File: rtl/slice_stage_sequencer.sv
// Per-slice stage sequencer. A start pulse in IDLE latches the slice block
// count, precomputes every stage window [B_s, E_s) and the run length END,
// then runs a global counter from 0 to END before returning to IDLE.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   start          in   start request, sampled only in IDLE
//   block_num      in   blocks in the slice, latched on accepted start
//   abort          in   (SLICE_SEQ_ABORT_EN only) leave RUN on next edge
//   busy           out  state is RUN
//   done           out  last RUN cycle (seq_counter == END)
//   seq_counter    out  global counter, 0 in IDLE
//   stage_active   out  per-stage window active
//   stage_flush    out  per-stage pulse on the cycle after the window
//   stage_counter  out  per-stage local count, 0 outside the window
// Optional feature macro: SLICE_SEQ_ABORT_EN adds the abort port.
module slice_stage_sequencer
    import slice_seq_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 32,
    parameter int BLK_W      = 6,
    parameter logic [NUM_STAGES*FIELD_W-1:0] STAGE_DELAY = DEF_STAGE_DELAY,
    parameter logic [NUM_STAGES*FIELD_W-1:0] STAGE_CPB   = DEF_STAGE_CPB
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [BLK_W-1:0]                     block_num,
`ifdef SLICE_SEQ_ABORT_EN
    input  logic                                 abort,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic [CNT_W-1:0]                     seq_counter,
    output logic [NUM_STAGES-1:0]                stage_active,
    output logic [NUM_STAGES-1:0]                stage_flush,
    output logic [NUM_STAGES-1:0][CNT_W-1:0]     stage_counter
);

    // Worst-case window end over all stages at the largest block count.
    function automatic logic [63:0] worst_span();
        logic [63:0] w;
        logic [63:0] m;
        m = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            w = 64'(STAGE_DELAY[s*FIELD_W +: FIELD_W])
              + (64'(STAGE_CPB[s*FIELD_W +: FIELD_W]) + 64'd1)
              * ((64'd1 << BLK_W) - 64'd1);
            if (w > m) m = w;
        end
        return m;
    endfunction

    localparam logic [63:0] WORST = worst_span();

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_stage_range_err
        $error("slice_stage_sequencer: NUM_STAGES must be 1..8");
    end
    if (CNT_W < 64 && WORST >= (64'd1 << CNT_W)) begin : g_cnt_range_err
        $error("slice_stage_sequencer: CNT_W too narrow, counter would wrap");
    end

    state_t state, state_n;
    logic   run, load, leave;
    logic   abort_req;

    logic [NUM_STAGES-1:0][CNT_W-1:0] beg_q, fin_q, beg_n, fin_n;
    logic [CNT_W-1:0]                 end_q, end_n;

`ifdef SLICE_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign run  = (state == RUN);
    assign load = (state == IDLE) && start;

    // Window bounds for the incoming slice, computed from block_num directly
    // so they are ready to register on the accepting edge.
    always_comb begin
        beg_n = '0;
        fin_n = '0;
        end_n = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            beg_n[s] = CNT_W'(STAGE_DELAY[s*FIELD_W +: FIELD_W]) + CNT_W'(block_num);
            fin_n[s] = beg_n[s]
                     + CNT_W'(STAGE_CPB[s*FIELD_W +: FIELD_W]) * CNT_W'(block_num);
            if (fin_n[s] > end_n) end_n = fin_n[s];
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        leave   = 1'b0;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (abort_req || (seq_counter == end_q)) begin
                    state_n = IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_counter <= '0;
            beg_q       <= '0;
            fin_q       <= '0;
            end_q       <= '0;
        end else if (load) begin
            seq_counter <= '0;
            beg_q       <= beg_n;
            fin_q       <= fin_n;
            end_q       <= end_n;
        end else if (run) begin
            seq_counter <= leave ? '0 : seq_counter + 1'b1;
        end
    end

    assign busy = run;
    assign done = run && (seq_counter == end_q);

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        slice_stage_window #(.CNT_W(CNT_W)) u_win (
            .run       (run),
            .beg       (beg_q[s]),
            .fin       (fin_q[s]),
            .count     (seq_counter),
            .active    (stage_active[s]),
            .flush     (stage_flush[s]),
            .local_cnt (stage_counter[s])
        );
    end

endmodule

// File: tb/tb_slice_stage_sequencer.sv
module tb_slice_stage_sequencer;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [5:0]      block_num = '0;
    logic            abort = 1'b0;
    logic            busy, done;
    logic [31:0]     seq_counter;
    logic [1:0]      stage_active, stage_flush;
    logic [1:0][31:0] stage_counter;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    slice_stage_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .block_num     (block_num),
`ifdef SLICE_SEQ_ABORT_EN
        .abort         (abort),
`endif
        .busy          (busy),
        .done          (done),
        .seq_counter   (seq_counter),
        .stage_active  (stage_active),
        .stage_flush   (stage_flush),
        .stage_counter (stage_counter)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  64'(busy),          64'd0);
        chk({tag, ".done"},  64'(done),          64'd0);
        chk({tag, ".cnt"},   64'(seq_counter),   64'd0);
        chk({tag, ".act"},   64'(stage_active),  64'd0);
        chk({tag, ".flush"}, 64'(stage_flush),   64'd0);
        chk({tag, ".sc0"},   64'(stage_counter[0]), 64'd0);
        chk({tag, ".sc1"},   64'(stage_counter[1]), 64'd0);
    endtask

    // Runs one slice and checks every output on every cycle against the
    // hand-computed windows [b0,e0), [b1,e1) and run length endc.
    // restart_at: counter value at which start is pulsed again (block_num=7).
    // rst_at:     counter value at which reset is asserted (slice abandoned).
    // abort_at:   counter value at which abort is raised.
    task automatic run_slice(input int bn, input int b0, input int e0,
                             input int b1, input int e1, input int endc,
                             input int restart_at, input int rst_at, input int abort_at);
        bit running;
        bit a0, a1, f0, f1;
        @(negedge clock);
        block_num = 6'(bn);
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 0; k <= endc + 2; k++) begin
            @(negedge clock);
            running = (k <= endc) && !(abort_at >= 0 && k > abort_at);
            a0 = running && k >= b0 && k < e0;
            a1 = running && k >= b1 && k < e1;
            f0 = running && k == e0;
            f1 = running && k == e1;
            chk($sformatf("busy@%0d", k),  64'(busy),            64'(running));
            chk($sformatf("done@%0d", k),  64'(done),            64'(running && k == endc));
            chk($sformatf("cnt@%0d", k),   64'(seq_counter),     running ? 64'(k) : 64'd0);
            chk($sformatf("act@%0d", k),   64'(stage_active),    64'({a1, a0}));
            chk($sformatf("flush@%0d", k), 64'(stage_flush),     64'({f1, f0}));
            chk($sformatf("sc0@%0d", k),   64'(stage_counter[0]), a0 ? 64'(k - b0) : 64'd0);
            chk($sformatf("sc1@%0d", k),   64'(stage_counter[1]), a1 ? 64'(k - b1) : 64'd0);
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                chk_idle($sformatf("rst_async@%0d", k));
                @(negedge clock);
                chk_idle("rst_hold");
                reset = 1'b0;
                break;
            end
            start     = (k == restart_at);
            block_num = (k == restart_at) ? 6'd7 : 6'(bn);
            abort     = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Reset state.
        #12;
        chk_idle("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_idle("post_reset");

        // bn=4: stage0 [14,18), stage1 [58,310), END 310.
        run_slice(4, 14, 18, 58, 310, 310, -1, -1, -1);

        // bn=0: empty windows, flushes at 10 and 54, done at 54;
        // start pulsed on the done edge must be ignored.
        run_slice(0, 10, 10, 54, 54, 54, 54, -1, -1);

        // Mid-RUN start with block_num=7 is ignored; bn=4 windows hold.
        run_slice(4, 14, 18, 58, 310, 310, 30, -1, -1);

        // Reset at counter 100, then bn=1: stage0 active at 11 only.
        run_slice(4, 14, 18, 58, 310, 310, -1, 100, -1);
        run_slice(1, 11, 12, 55, 118, 118, -1, -1, -1);

        // bn=63: stage0 [73,136), stage1 [117,4086), END 4086.
        run_slice(63, 73, 136, 117, 4086, 4086, -1, -1, -1);

`ifdef SLICE_SEQ_ABORT_EN
        // Abort at counter 20: idle from the next cycle, no stage1, no done.
        run_slice(4, 14, 18, 58, 310, 310, -1, -1, 20);
        // Abort in IDLE does nothing.
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk_idle("abort_idle");
`endif

        @(negedge clock);
        chk_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
